// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg : shared types and field-width helpers for the data cache
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

  localparam int unsigned DC_NSETS     = 16;
  localparam int unsigned DC_LINEWORDS = 4;

  function automatic int unsigned dc_word_w(input int unsigned linewords);
    return $clog2(linewords);
  endfunction

  function automatic int unsigned dc_set_w(input int unsigned nsets);
    return $clog2(nsets);
  endfunction

  // Tag covers everything above the byte, word and set fields.
  function automatic int unsigned dc_tag_w(input int unsigned nsets, input int unsigned linewords);
    return 30 - $clog2(linewords) - $clog2(nsets);
  endfunction

  typedef enum logic [1:0] {
    DC_IDLE   = 2'd0,
    DC_REFILL = 2'd1,
    DC_WRITE  = 2'd2,
    DC_RESUME = 2'd3
  } dcstate_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } dcreq_t;

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array : valid/tag/data storage, combinational read, synchronous write
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_array #(
  parameter int unsigned NSETS     = 16,
  parameter int unsigned LINEWORDS = 4,
  parameter int unsigned TAG_W     = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [$clog2(NSETS)-1:0]     rd_set_i,
  input  logic [$clog2(LINEWORDS)-1:0] rd_word_i,
  output logic                         rd_valid_o,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic [31:0]                  rd_data_o,
  input  logic                         wr_en_i,
  input  logic [$clog2(NSETS)-1:0]     wr_set_i,
  input  logic [$clog2(LINEWORDS)-1:0] wr_word_i,
  input  logic [31:0]                  wr_data_i,
  input  logic                         tag_we_i,
  input  logic [TAG_W-1:0]             tag_i
);

  logic [NSETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [31:0]      data_q [NSETS][LINEWORDS];

  assign rd_valid_o = valid_q[rd_set_i];
  assign rd_tag_o   = tag_q[rd_set_i];
  assign rd_data_o  = data_q[rd_set_i][rd_word_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[wr_set_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone decides whether they count.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[wr_set_i] <= tag_i;
    end
    if (wr_en_i) begin
      data_q[wr_set_i][wr_word_i] <= wr_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache.sv
// ---------------------------------------------------------------------------
// dcache : direct-mapped write-through no-write-allocate data cache
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned NSETS     = DC_NSETS,
  parameter int unsigned LINEWORDS = DC_LINEWORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned WORD_W = dc_word_w(LINEWORDS);
  localparam int unsigned SET_W  = dc_set_w(NSETS);
  localparam int unsigned TAG_W  = dc_tag_w(NSETS, LINEWORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINEWORDS - 1);

  dcstate_t          state_q, state_d;
  dcreq_t            req_q, req_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;

  logic [31:0]       w_addr;
  logic [SET_W-1:0]  w_set;
  logic [WORD_W-1:0] w_word;
  logic [TAG_W-1:0]  w_tag;
  logic              w_arr_valid;
  logic [TAG_W-1:0]  w_arr_tag;
  logic [31:0]       w_arr_data;
  logic              w_hit;
  logic              w_wr_en;
  logic [WORD_W-1:0] w_wr_word;
  logic [31:0]       w_wr_data;
  logic              w_tag_we;
  logic              w_unused;

  // Outside IDLE the latched request owns the array lookup.
  assign w_addr   = (state_q == DC_IDLE) ? addrM : req_q.addr;
  assign w_word   = w_addr[2 +: WORD_W];
  assign w_set    = w_addr[2 + WORD_W +: SET_W];
  assign w_tag    = w_addr[2 + WORD_W + SET_W +: TAG_W];
  assign w_hit    = w_arr_valid && (w_arr_tag == w_tag);
  assign w_unused = ^w_addr[1:0];

  dcache_array #(
    .NSETS     (NSETS),
    .LINEWORDS (LINEWORDS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk_i      (clk),
    .rst_i      (reset),
    .rd_set_i   (w_set),
    .rd_word_i  (w_word),
    .rd_valid_o (w_arr_valid),
    .rd_tag_o   (w_arr_tag),
    .rd_data_o  (w_arr_data),
    .wr_en_i    (w_wr_en),
    .wr_set_i   (w_set),
    .wr_word_i  (w_wr_word),
    .wr_data_i  (w_wr_data),
    .tag_we_i   (w_tag_we),
    .tag_i      (w_tag)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    readdataM = '0;
    stallM    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_wr_en   = 1'b0;
    w_wr_word = w_word;
    w_wr_data = req_q.data;
    w_tag_we  = 1'b0;
    case (state_q)
      DC_IDLE: begin
        if (memreadM && w_hit) begin
          readdataM = w_arr_data;
        end
        if (memwriteM) begin
          stallM     = 1'b1;
          req_d.addr = addrM;
          req_d.data = writedataM;
          state_d    = DC_WRITE;
        end else if (memreadM && !w_hit) begin
          stallM     = 1'b1;
          req_d.addr = addrM;
          cnt_d      = '0;
          state_d    = DC_REFILL;
        end
      end
      DC_REFILL: begin
        stallM   = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_q.addr[31:2+WORD_W], cnt_q, 2'b00};
        if (mem_ack) begin
          w_wr_en   = 1'b1;
          w_wr_word = cnt_q;
          w_wr_data = mem_rdata;
          cnt_d     = cnt_q + WORD_W'(1);
          if (cnt_q == LAST_WORD) begin
            w_tag_we = 1'b1;
            state_d  = DC_RESUME;
          end
        end
      end
      DC_WRITE: begin
        stallM    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {req_q.addr[31:2], 2'b00};
        mem_wdata = req_q.data;
        if (mem_ack) begin
          w_wr_en = w_hit;
          state_d = DC_RESUME;
        end
      end
      DC_RESUME: begin
        if (memreadM && w_hit) begin
          readdataM = w_arr_data;
        end
        state_d = DC_IDLE;
      end
      default: state_d = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DC_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire
